// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: parameter legality
// check and the per-stage pipeline record.
package adder_pkg;

    // Upper bound on WIDTH; residual operands and partial sums live in fields this wide.
    localparam int ADDER_MAX_W = 64;

    typedef struct packed {
        logic                   valid;
        logic                   carry;
        logic                   ovf;
        logic                   zero;
        logic [ADDER_MAX_W-1:0] sum;
        logic [ADDER_MAX_W-1:0] a_rem;
        logic [ADDER_MAX_W-1:0] b_rem;
    } pipe_rec_t;

    function automatic logic adder_params_ok(input int width, input int stages);
        logic ok;
        ok = 1'b1;
        if (width < 2)                 ok = 1'b0;
        if (width > ADDER_MAX_W)       ok = 1'b0;
        if (stages < 1)                ok = 1'b0;
        if (stages > width)            ok = 1'b0;
        if (stages >= 1 && (width % stages) != 0) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/add_seg.sv
// Combinational SEG-bit ripple segment; also exposes the carry into its MSB
// so the final segment can derive signed overflow.
module add_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_c_msb
);

    logic [SEG:0] c;

    assign c[0] = i_cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (c[i]),
            .o_s (o_sum[i]),
            .o_c (c[i+1])
        );
    end

    assign o_cout  = c[SEG];
    assign o_c_msb = c[SEG-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple segments.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic half;

    assign half = i_a ^ i_b;
    assign o_s  = half ^ i_c;
    assign o_c  = (i_a & i_b) | (i_c & half);

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/sub: the carry chain is cut into STAGES segments, each with its
// own register stage, elastic valid/ready handshake and registered flags.
module pipe_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic             i_sub,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!adder_params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipe_add_sub: WIDTH must be >= 2, <= ADDER_MAX_W and divisible by STAGES");
    end

    pipe_rec_t stage_q [STAGES];
    pipe_rec_t stage_d [STAGES];

    logic [ADDER_MAX_W-1:0] a_ext;
    logic [ADDER_MAX_W-1:0] b_ext;
    logic                   c0;

    logic [ADDER_MAX_W-1:0] prev_sum [STAGES];
    logic [ADDER_MAX_W-1:0] prev_a   [STAGES];
    logic [ADDER_MAX_W-1:0] prev_b   [STAGES];
    logic                   in_v     [STAGES];

    logic [SEG-1:0] seg_a    [STAGES];
    logic [SEG-1:0] seg_b    [STAGES];
    logic [SEG-1:0] seg_sum  [STAGES];
    logic           seg_cin  [STAGES];
    logic           seg_cout [STAGES];
    logic           seg_cmsb [STAGES];

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;

    // Operand feed for each segment: stage 0 takes the ports, stage k takes
    // the residual operands and carry registered by stage k-1.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[WIDTH-1:0] = i_data_a;
        b_ext[WIDTH-1:0] = i_sub ? ~i_data_b : i_data_b;
        c0 = i_sub | i_cin;

        prev_sum[0] = '0;
        prev_a[0]   = a_ext;
        prev_b[0]   = b_ext;
        in_v[0]     = i_valid;
        seg_cin[0]  = c0;
        for (int k = 1; k < STAGES; k++) begin
            prev_sum[k] = stage_q[k-1].sum;
            prev_a[k]   = stage_q[k-1].a_rem;
            prev_b[k]   = stage_q[k-1].b_rem;
            in_v[k]     = stage_q[k-1].valid;
            seg_cin[k]  = stage_q[k-1].carry;
        end

        for (int k = 0; k < STAGES; k++) begin
            seg_a[k] = prev_a[k][SEG-1:0];
            seg_b[k] = prev_b[k][SEG-1:0];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        add_seg #(.SEG(SEG)) u_seg (
            .i_a     (seg_a[k]),
            .i_b     (seg_b[k]),
            .i_cin   (seg_cin[k]),
            .o_sum   (seg_sum[k]),
            .o_cout  (seg_cout[k]),
            .o_c_msb (seg_cmsb[k])
        );
    end

    // Handshake: a transfer happens on an edge where valid & ready are both high;
    // valid never waits on ready. Stage k advances when it holds data and its
    // successor is empty or advancing, so bubbles collapse and o_ready = load[0].
    always_comb begin
        logic down_ok;
        down_ok = i_ready;
        adv  = '0;
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            v[k] = stage_q[k].valid;
        end
        for (int k = LAST; k >= 0; k--) begin
            adv[k]  = v[k] & down_ok;
            load[k] = ~v[k] | adv[k];
            down_ok = load[k];
        end
    end

    always_comb begin
        logic [ADDER_MAX_W-1:0] seg_ext;
        stage_d = stage_q;
        for (int k = 0; k < STAGES; k++) begin
            seg_ext = '0;
            seg_ext[SEG-1:0] = seg_sum[k];
            if (load[k]) begin
                stage_d[k].valid = in_v[k];
                if (in_v[k]) begin
                    stage_d[k].sum   = prev_sum[k] | (seg_ext << (k * SEG));
                    stage_d[k].a_rem = prev_a[k] >> SEG;
                    stage_d[k].b_rem = prev_b[k] >> SEG;
                    stage_d[k].carry = seg_cout[k];
                    stage_d[k].ovf   = (k == LAST) & (seg_cmsb[k] ^ seg_cout[k]);
                    stage_d[k].zero  = (k == LAST) & (stage_d[k].sum == '0);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_ready = load[0];
    assign o_valid = stage_q[LAST].valid;
    assign o_data  = stage_q[LAST].sum[WIDTH-1:0];
    assign o_carry = stage_q[LAST].carry;
    assign o_ovf   = stage_q[LAST].ovf;
    assign o_zero  = stage_q[LAST].zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed bench for pipe_add_sub: 32-bit/4-stage instance plus an 8-bit/1-stage instance.
module tb_pipe_add_sub;

    localparam int W = 32;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sub, in_cin, out_ready;
    logic [31:0] in_a, in_b;
    logic        dut_ready, dut_valid, dut_carry, dut_ovf, dut_zero;
    logic [31:0] dut_data;

    logic        n_valid, n_sub, n_cin, n_out_ready;
    logic [7:0]  n_a, n_b;
    logic        n_ready, n_ovalid, n_carry, n_ovf, n_zero;
    logic [7:0]  n_data;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(dut_ready),
        .i_data_a(in_a), .i_data_b(in_b), .i_sub(in_sub), .i_cin(in_cin),
        .o_valid(dut_valid), .i_ready(out_ready), .o_data(dut_data),
        .o_carry(dut_carry), .o_ovf(dut_ovf), .o_zero(dut_zero)
    );

    pipe_add_sub #(.WIDTH(8), .STAGES(1)) u_narrow (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(n_valid), .o_ready(n_ready),
        .i_data_a(n_a), .i_data_b(n_b), .i_sub(n_sub), .i_cin(n_cin),
        .o_valid(n_ovalid), .i_ready(n_out_ready), .o_data(n_data),
        .o_carry(n_carry), .o_ovf(n_ovf), .o_zero(n_zero)
    );

    // Reference: {carry, ovf, zero, data}
    function automatic logic [34:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic cin);
        logic [31:0] bb;
        logic [32:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {32'b0, (sub ? 1'b1 : cin)};
        ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        return {full[32], ovf, (full[31:0] == 32'h0), full[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin);
        in_valid = v; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
    endtask

    task automatic n_drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic sub, input logic cin);
        n_valid = v; n_a = a; n_b = b; n_sub = sub; n_cin = cin;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0);
        n_drive(0, 8'h0, 8'h0, 0, 0);
        out_ready = 1'b1;
        n_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        vec_cnt++;
        if ({dut_valid, dut_data, dut_carry, dut_ovf, dut_zero, dut_ready} !== {1'b0, 32'h0, 4'b0001}) begin
            err_cnt++;
            $display("FAIL reset_wide: got v=%b d=%h c=%b o=%b z=%b r=%b, expected v=0 d=0 c=0 o=0 z=0 r=1",
                     dut_valid, dut_data, dut_carry, dut_ovf, dut_zero, dut_ready);
        end
        vec_cnt++;
        if ({n_ovalid, n_data, n_carry, n_ovf, n_zero, n_ready} !== {1'b0, 8'h0, 4'b0001}) begin
            err_cnt++;
            $display("FAIL reset_narrow: got v=%b d=%h c=%b o=%b z=%b r=%b, expected v=0 d=0 c=0 o=0 z=0 r=1",
                     n_ovalid, n_data, n_carry, n_ovf, n_zero, n_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_wrap();
        out_ready = 1'b1;
        drive(1, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0);
        #1;
        vec_cnt++;
        if (dut_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL add_ready: got %b expected 1", dut_ready);
        end
        step();
        drive(0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < S - 1; i++) begin
            #1;
            vec_cnt++;
            if (dut_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL add_latency: o_valid=%b at cycle %0d, expected 0", dut_valid, i + 1);
            end
            step();
        end
        #1;
        vec_cnt++;
        if ({dut_valid, dut_carry, dut_ovf, dut_zero, dut_data} !== {4'b1101, 32'h0}) begin
            err_cnt++;
            $display("FAIL add_wrap: got v=%b c=%b o=%b z=%b d=%h, expected v=1 c=1 o=0 z=1 d=00000000",
                     dut_valid, dut_carry, dut_ovf, dut_zero, dut_data);
        end
        step();
    endtask

    task automatic test_sub();
        logic [34:0] exp_v;
        out_ready = 1'b1;
        drive(1, 32'h8000_0000, 32'h0000_0001, 1, 0);
        exp_q.push_back({3'b110, 32'h7FFF_FFFF});
        step();
        drive(1, 32'h0000_0005, 32'h0000_0007, 1, 1);
        exp_q.push_back({3'b000, 32'hFFFF_FFFE});
        step();
        drive(0, 32'h0, 32'h0, 0, 0);
        for (int cyc = 0; cyc < 12 && exp_q.size() != 0; cyc++) begin
            #1;
            if (dut_valid && out_ready) begin
                exp_v = exp_q.pop_front();
                vec_cnt++;
                if ({dut_carry, dut_ovf, dut_zero, dut_data} !== exp_v) begin
                    err_cnt++;
                    $display("FAIL sub_result: got c/o/z=%b%b%b d=%h, expected c/o/z=%b d=%h",
                             dut_carry, dut_ovf, dut_zero, dut_data, exp_v[34:32], exp_v[31:0]);
                end
            end
            step();
        end
        if (exp_q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL sub_timeout: %0d results missing, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        sub, cin;
        logic [34:0] exp_v;
        int          pops;
        pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            if (i == 5) begin a = 32'h7FFF_FFFF; b = 32'h0000_0001; sub = 0; cin = 0; end
            if (i == 9) begin a = 32'h1234_5678; b = 32'h1234_5678; sub = 1; cin = 0; end
            drive(1, a, b, sub, cin);
            #1;
            if (dut_valid) begin
                pops++;
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL b2b_spurious: got result d=%h, expected none", dut_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({dut_carry, dut_ovf, dut_zero, dut_data} !== exp_v) begin
                        err_cnt++;
                        $display("FAIL b2b_result: got c/o/z=%b%b%b d=%h, expected c/o/z=%b d=%h",
                                 dut_carry, dut_ovf, dut_zero, dut_data, exp_v[34:32], exp_v[31:0]);
                    end
                end
            end
            vec_cnt++;
            if (dut_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL b2b_ready: got %b at op %0d, expected 1", dut_ready, i);
            end
            if (dut_ready) exp_q.push_back(ref_op(a, b, sub, cin));
            step();
        end
        drive(0, 32'h0, 32'h0, 0, 0);
        vec_cnt++;
        if (pops != 64 - S) begin
            err_cnt++;
            $display("FAIL b2b_throughput: got %0d results during stream, expected %0d", pops, 64 - S);
        end
        for (int cyc = 0; cyc < S && exp_q.size() != 0; cyc++) begin
            #1;
            if (dut_valid) begin
                exp_v = exp_q.pop_front();
                vec_cnt++;
                if ({dut_carry, dut_ovf, dut_zero, dut_data} !== exp_v) begin
                    err_cnt++;
                    $display("FAIL b2b_drain: got c/o/z=%b%b%b d=%h, expected c/o/z=%b d=%h",
                             dut_carry, dut_ovf, dut_zero, dut_data, exp_v[34:32], exp_v[31:0]);
                end
            end
            step();
        end
        if (exp_q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL b2b_timeout: %0d results missing, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_full_stall();
        int          acc;
        logic [34:0] exp_v;
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h100 + 32'(i), 32'(i * 3), 0, 0);
            #1;
            if (dut_ready) begin
                exp_q.push_back({3'b000, 32'h100 + 32'(4 * i)});
                acc++;
            end
            step();
        end
        #1;
        vec_cnt++;
        if (acc != S) begin
            err_cnt++;
            $display("FAIL stall_accepts: got %0d accepted, expected %0d", acc, S);
        end
        vec_cnt++;
        if (dut_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_ready: got %b, expected 0", dut_ready);
        end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (dut_valid !== 1'b1 || dut_data !== 32'h0000_0100) begin
                err_cnt++;
                $display("FAIL stall_hold: got v=%b d=%h, expected v=1 d=00000100", dut_valid, dut_data);
            end
            step();
            #1;
        end
        out_ready = 1'b1;
        drive(1, 32'h200, 32'h5, 0, 0);
        #1;
        vec_cnt++;
        if (dut_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_release_ready: got %b, expected 1", dut_ready);
        end
        if (dut_ready) exp_q.push_back({3'b000, 32'h0000_0205});
        for (int cyc = 0; cyc < 2 * S + 2 && exp_q.size() != 0; cyc++) begin
            if (cyc == 0) begin
                #0;
            end else begin
                #1;
            end
            if (dut_valid) begin
                exp_v = exp_q.pop_front();
                vec_cnt++;
                if ({dut_carry, dut_ovf, dut_zero, dut_data} !== exp_v) begin
                    err_cnt++;
                    $display("FAIL stall_drain: got c/o/z=%b%b%b d=%h, expected c/o/z=%b d=%h",
                             dut_carry, dut_ovf, dut_zero, dut_data, exp_v[34:32], exp_v[31:0]);
                end
            end
            step();
            drive(0, 32'h0, 32'h0, 0, 0);
        end
        if (exp_q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL stall_timeout: %0d results missing, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h11 * 32'(i + 1), 32'h22, 0, 0);
            step();
        end
        drive(0, 32'h0, 32'h0, 0, 0);
        step();
        #1;
        vec_cnt++;
        if (dut_valid !== 1'b1 || dut_data !== 32'h0000_0033) begin
            err_cnt++;
            $display("FAIL rstmid_pre: got v=%b d=%h, expected v=1 d=00000033", dut_valid, dut_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({dut_valid, dut_data, dut_carry, dut_ovf, dut_zero, dut_ready} !== {1'b0, 32'h0, 4'b0001}) begin
            err_cnt++;
            $display("FAIL rstmid_async: got v=%b d=%h c=%b o=%b z=%b r=%b, expected v=0 d=0 c=0 o=0 z=0 r=1",
                     dut_valid, dut_data, dut_carry, dut_ovf, dut_zero, dut_ready);
        end
        step();
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            vec_cnt++;
            if (dut_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL rstmid_stale: got o_valid=%b %0d cycles after release, expected 0", dut_valid, i + 1);
            end
        end
        drive(1, 32'h3, 32'h4, 0, 0);
        step();
        drive(0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < S - 1; i++) begin
            #1;
            vec_cnt++;
            if (dut_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL rstmid_latency: o_valid=%b at cycle %0d, expected 0", dut_valid, i + 1);
            end
            step();
        end
        #1;
        vec_cnt++;
        if (dut_valid !== 1'b1 || dut_data !== 32'h0000_0007) begin
            err_cnt++;
            $display("FAIL rstmid_new: got v=%b d=%h, expected v=1 d=00000007", dut_valid, dut_data);
        end
        step();
    endtask

    task automatic test_narrow();
        n_out_ready = 1'b1;
        n_drive(1, 8'h7F, 8'h01, 0, 0);
        #1;
        vec_cnt++;
        if (n_ovalid !== 1'b0 || n_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL narrow_idle: got v=%b r=%b, expected v=0 r=1", n_ovalid, n_ready);
        end
        step();
        n_drive(1, 8'hFF, 8'h00, 0, 1);
        #1;
        vec_cnt++;
        if ({n_ovalid, n_carry, n_ovf, n_zero, n_data} !== {4'b1010, 8'h80}) begin
            err_cnt++;
            $display("FAIL narrow_ovf: got v=%b c=%b o=%b z=%b d=%h, expected v=1 c=0 o=1 z=0 d=80",
                     n_ovalid, n_carry, n_ovf, n_zero, n_data);
        end
        step();
        n_drive(1, 8'h03, 8'h05, 1, 0);
        #1;
        vec_cnt++;
        if ({n_ovalid, n_carry, n_ovf, n_zero, n_data} !== {4'b1101, 8'h00}) begin
            err_cnt++;
            $display("FAIL narrow_cin: got v=%b c=%b o=%b z=%b d=%h, expected v=1 c=1 o=0 z=1 d=00",
                     n_ovalid, n_carry, n_ovf, n_zero, n_data);
        end
        step();
        n_drive(0, 8'h00, 8'h00, 0, 0);
        #1;
        vec_cnt++;
        if ({n_ovalid, n_carry, n_ovf, n_zero, n_data} !== {4'b1000, 8'hFE}) begin
            err_cnt++;
            $display("FAIL narrow_sub: got v=%b c=%b o=%b z=%b d=%h, expected v=1 c=0 o=0 z=0 d=fe",
                     n_ovalid, n_carry, n_ovf, n_zero, n_data);
        end
        step();
        #1;
        vec_cnt++;
        if (n_ovalid !== 1'b0) begin
            err_cnt++;
            $display("FAIL narrow_empty: got v=%b, expected 0", n_ovalid);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_back_to_back();
        test_full_stall();
        test_reset_mid();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
